// File: rtl/seg_scan_ctrl.sv
// Eight-digit multiplexed seven-segment driver with tear-free shadow/display
// registers, leading-zero suppression and an anti-ghosting dead window.
module seg_scan_ctrl #(
  parameter int unsigned DIV  = 100000,
  parameter int unsigned DEAD = 2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        load,
  input  logic [31:0] data,
  input  logic [7:0]  point,
  input  logic [7:0]  blank,
  input  logic        lz_en,
  output logic [7:0]  an,
  output logic [7:0]  seg,
  output logic [2:0]  digit,
  output logic        pending
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;
  logic [31:0]   sh_data, dp_data;
  logic [7:0]    sh_point, sh_blank, dp_point, dp_blank;
  logic          tick, boundary, commit;
  logic [7:0]    lz_dark;
  logic [3:0]    nib;
  logic [6:0]    hex;
  logic          dark;

  assign tick     = en && (cnt == CW'(DIV - 1));
  assign boundary = tick && (digit == 3'd7);
  assign commit   = boundary && (pending || load);

  always_comb begin
    lz_dark = '0;
    for (int unsigned i = 1; i < 8; i++) begin
      lz_dark[i] = lz_en && ((dp_data >> (4 * i)) == 32'd0);
    end
    nib  = dp_data[digit*4 +: 4];
    dark = dp_blank[digit] || lz_dark[digit] || (32'(cnt) < DEAD) || !en;
    hex  = 7'h7F;
    case (nib)
      4'h0: hex = 7'h40;
      4'h1: hex = 7'h79;
      4'h2: hex = 7'h24;
      4'h3: hex = 7'h30;
      4'h4: hex = 7'h19;
      4'h5: hex = 7'h12;
      4'h6: hex = 7'h02;
      4'h7: hex = 7'h78;
      4'h8: hex = 7'h00;
      4'h9: hex = 7'h10;
      4'hA: hex = 7'h08;
      4'hB: hex = 7'h03;
      4'hC: hex = 7'h46;
      4'hD: hex = 7'h21;
      4'hE: hex = 7'h06;
      4'hF: hex = 7'h0E;
      default: hex = 7'h7F;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      digit    <= '0;
      pending  <= 1'b0;
      sh_data  <= '0;
      sh_point <= '0;
      sh_blank <= '0;
      dp_data  <= '0;
      dp_point <= '0;
      dp_blank <= '0;
      an       <= '1;
      seg      <= '1;
    end else begin
      if (tick) begin
        cnt   <= '0;
        digit <= digit + 3'd1;
      end else if (en) begin
        cnt <= cnt + 1'b1;
      end

      if (load) begin
        sh_data  <= data;
        sh_point <= point;
        sh_blank <= blank;
      end

      // A load landing on the boundary bypasses the shadow so it is not lost.
      if (commit) begin
        dp_data  <= load ? data  : sh_data;
        dp_point <= load ? point : sh_point;
        dp_blank <= load ? blank : sh_blank;
        pending  <= 1'b0;
      end else if (load) begin
        pending <= 1'b1;
      end

      an  <= dark ? 8'hFF : ~(8'h01 << digit);
      seg <= {~dp_point[digit], hex};
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: directed scenarios plus random traffic,
// all checked against a frame-position reference model.
module tb_seg_scan_ctrl;

  localparam int unsigned DIV   = 4;
  localparam int unsigned DEAD  = 1;
  localparam int unsigned FRAME = 8 * DIV;

  logic        clk = 1'b0;
  logic        rst, en, load, lz_en;
  logic [31:0] data;
  logic [7:0]  point, blank;
  logic [7:0]  an, seg;
  logic [2:0]  digit;
  logic        pending;

  int n_cmp = 0;
  int n_bad = 0;

  seg_scan_ctrl #(.DIV(DIV), .DEAD(DEAD)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .data(data),
    .point(point), .blank(blank), .lz_en(lz_en),
    .an(an), .seg(seg), .digit(digit), .pending(pending)
  );

  always #5 clk = ~clk;

  // Reference model: scan position within the frame plus shadow/display words.
  logic [6:0]  hexlut [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  int unsigned m_pos, m_opos;
  bit          m_pend, m_committed;
  logic [31:0] m_shd, m_dd;
  logic [7:0]  m_shp, m_shb, m_dp, m_db;
  logic [7:0]  e_an, e_seg;
  logic [2:0]  e_dig;
  logic        e_pend;

  task automatic step();
    int unsigned d, c, nb;
    bit dk;
    if (rst) begin
      m_pos = 0; m_pend = 0; m_opos = FRAME;
      m_shd = '0; m_shp = '0; m_shb = '0;
      m_dd = '0; m_dp = '0; m_db = '0;
      e_an = 8'hFF; e_seg = 8'hFF;
    end else begin
      d  = m_pos / DIV;
      c  = m_pos % DIV;
      nb = (m_dd >> (4 * d)) & 32'hF;
      dk = m_db[d] || (lz_en && d != 0 && (m_dd >> (4 * d)) == 0) || c < DEAD || !en;
      e_an   = dk ? 8'hFF : ~(8'h01 << d);
      e_seg  = {~m_dp[d], hexlut[nb]};
      m_opos = m_pos;
      if (en && m_pos == FRAME - 1 && (m_pend || load)) begin
        m_dd = load ? data  : m_shd;
        m_dp = load ? point : m_shp;
        m_db = load ? blank : m_shb;
        m_pend = 0;
        m_committed = 1;
      end else if (load) begin
        m_pend = 1;
      end
      if (load) begin
        m_shd = data; m_shp = point; m_shb = blank;
      end
      if (en) m_pos = (m_pos + 1) % FRAME;
    end
    e_dig  = 3'(m_pos / DIV);
    e_pend = m_pend;
    @(posedge clk);
    #1;
  endtask

  task automatic advance_to_pos(input int unsigned p);
    for (int i = 0; i < 2 * FRAME && m_pos != p; i++) step();
  endtask

  task automatic advance_to_commit();
    m_committed = 0;
    for (int i = 0; i < 2 * FRAME && !m_committed; i++) step();
  endtask

  task automatic do_load(input logic [31:0] d, input logic [7:0] p, input logic [7:0] b);
    data = d; point = p; blank = b; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; lz_en = 1'b0;
    data = 32'hFFFF_FFFF; point = 8'hFF; blank = 8'h00; load = 1'b1;
    step();
    step();
    rst = 1'b0; load = 1'b0;
    n_cmp++;
    if (an !== 8'hFF || seg !== 8'hFF || digit !== 3'd0 || pending !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_values: an=%h seg=%h digit=%0d pending=%b, required FF FF 0 0",
               an, seg, digit, pending);
    end
    step();
    n_cmp++;
    if (an !== e_an || seg !== e_seg || digit !== e_dig || pending !== e_pend) begin
      n_bad++;
      $display("FAIL reset_idle: an=%h seg=%h digit=%0d pending=%b, required an=%h seg=%h digit=%0d pending=%b",
               an, seg, digit, pending, e_an, e_seg, e_dig, e_pend);
    end
  endtask

  task automatic test_first_load();
    en = 1'b1;
    do_load(32'h7654_3210, 8'h00, 8'h00);
    for (int k = 1; k < 2 * FRAME; k++) begin
      step();
      n_cmp++;
      if (an !== e_an || seg !== e_seg || digit !== e_dig || pending !== e_pend) begin
        n_bad++;
        $display("FAIL first_load: an=%h seg=%h digit=%0d pending=%b, required an=%h seg=%h digit=%0d pending=%b",
                 an, seg, digit, pending, e_an, e_seg, e_dig, e_pend);
      end
      if (k >= FRAME) begin
        if (m_opos % DIV == 0) begin
          n_cmp++;
          if (an !== 8'hFF) begin
            n_bad++;
            $display("FAIL slot_dead_cycle: an=%h, required FF", an);
          end
        end
        if (m_opos == 1) begin
          n_cmp++;
          if (an !== 8'hFE || seg !== 8'hC0) begin
            n_bad++;
            $display("FAIL first_digit0: an=%h seg=%h, required FE C0", an, seg);
          end
        end
        if (m_opos == 3 * DIV + 1) begin
          n_cmp++;
          if (an !== 8'hF7 || seg !== 8'hB0) begin
            n_bad++;
            $display("FAIL first_digit3: an=%h seg=%h, required F7 B0", an, seg);
          end
        end
      end
    end
  endtask

  task automatic test_tear_free();
    advance_to_pos(3 * DIV + 1);
    do_load(32'hFFFF_FFFF, 8'h00, 8'h00);
    m_committed = 0;
    for (int k = 0; k < FRAME + DIV; k++) begin
      step();
      n_cmp++;
      if (an !== e_an || seg !== e_seg || digit !== e_dig || pending !== e_pend) begin
        n_bad++;
        $display("FAIL tear_free: an=%h seg=%h digit=%0d pending=%b, required an=%h seg=%h digit=%0d pending=%b",
                 an, seg, digit, pending, e_an, e_seg, e_dig, e_pend);
      end
      if (!m_committed) begin
        n_cmp++;
        if (pending !== 1'b1) begin
          n_bad++;
          $display("FAIL tear_pending: pending=%b, required 1", pending);
        end
        if (m_opos / DIV >= 4 && m_opos % DIV >= DEAD) begin
          n_cmp++;
          if (seg[6:0] !== hexlut[m_opos / DIV]) begin
            n_bad++;
            $display("FAIL tear_old_nibble: seg=%h, required %h", seg[6:0], hexlut[m_opos / DIV]);
          end
        end
      end else if (m_opos == 1) begin
        n_cmp++;
        if (seg !== 8'h8E || pending !== 1'b0) begin
          n_bad++;
          $display("FAIL tear_new_word: seg=%h pending=%b, required 8E 0", seg, pending);
        end
      end
    end
  endtask

  task automatic test_boundary_load();
    advance_to_pos(FRAME - 1);
    do_load(32'h0000_000A, 8'h00, 8'h00);
    n_cmp++;
    if (pending !== 1'b0 || digit !== 3'd0) begin
      n_bad++;
      $display("FAIL boundary_pending: pending=%b digit=%0d, required 0 0", pending, digit);
    end
    for (int k = 0; k < 2 * DIV; k++) begin
      step();
      n_cmp++;
      if (an !== e_an || seg !== e_seg || digit !== e_dig || pending !== e_pend) begin
        n_bad++;
        $display("FAIL boundary_load: an=%h seg=%h digit=%0d pending=%b, required an=%h seg=%h digit=%0d pending=%b",
                 an, seg, digit, pending, e_an, e_seg, e_dig, e_pend);
      end
      if (m_opos == 1) begin
        n_cmp++;
        if (seg !== 8'h88 || an !== 8'hFE) begin
          n_bad++;
          $display("FAIL boundary_digit0: an=%h seg=%h, required FE 88", an, seg);
        end
      end
    end
  endtask

  task automatic test_leading_zero();
    logic [31:0] words [2] = '{32'h0000_0120, 32'h0000_0000};
    logic [7:0]  lit   [2] = '{8'h07, 8'h01};
    logic [7:0]  segs  [3] = '{8'hC0, 8'hA4, 8'hF9};
    lz_en = 1'b1;
    for (int w = 0; w < 2; w++) begin
      do_load(words[w], 8'h00, 8'h00);
      advance_to_commit();
      for (int k = 0; k < FRAME; k++) begin
        step();
        n_cmp++;
        if (an !== e_an || seg !== e_seg || digit !== e_dig || pending !== e_pend) begin
          n_bad++;
          $display("FAIL leading_zero: an=%h seg=%h digit=%0d pending=%b, required an=%h seg=%h digit=%0d pending=%b",
                   an, seg, digit, pending, e_an, e_seg, e_dig, e_pend);
        end
        if (m_opos % DIV >= DEAD) begin
          n_cmp++;
          if (lit[w][m_opos / DIV] ? (an !== ~(8'h01 << (m_opos / DIV)) || seg !== segs[m_opos / DIV])
                                   : (an !== 8'hFF)) begin
            n_bad++;
            $display("FAIL lz_digit%0d: an=%h seg=%h, lit required=%b", m_opos / DIV, an, seg,
                     lit[w][m_opos / DIV]);
          end
        end
      end
    end
    lz_en = 1'b0;
  endtask

  task automatic test_masks();
    do_load(32'h7654_3210, 8'h02, 8'h80);
    advance_to_commit();
    for (int k = 0; k < FRAME; k++) begin
      step();
      n_cmp++;
      if (an !== e_an || seg !== e_seg || digit !== e_dig || pending !== e_pend) begin
        n_bad++;
        $display("FAIL masks: an=%h seg=%h digit=%0d pending=%b, required an=%h seg=%h digit=%0d pending=%b",
                 an, seg, digit, pending, e_an, e_seg, e_dig, e_pend);
      end
      if (m_opos / DIV == 1 && m_opos % DIV >= DEAD) begin
        n_cmp++;
        if (seg !== 8'h79 || an !== 8'hFD) begin
          n_bad++;
          $display("FAIL point_digit1: an=%h seg=%h, required FD 79", an, seg);
        end
      end
      if (m_opos / DIV == 7) begin
        n_cmp++;
        if (an !== 8'hFF) begin
          n_bad++;
          $display("FAIL blank_digit7: an=%h, required FF", an);
        end
      end
    end
  endtask

  task automatic test_freeze_and_reset();
    advance_to_pos(5 * DIV + 2);
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (k == 4) do_load(32'h8888_8888, 8'h00, 8'h00);
      else step();
      n_cmp++;
      if (an !== 8'hFF || digit !== 3'd5 || an !== e_an || seg !== e_seg || pending !== e_pend) begin
        n_bad++;
        $display("FAIL freeze: an=%h seg=%h digit=%0d pending=%b, required an=FF seg=%h digit=5 pending=%b",
                 an, seg, digit, pending, e_seg, e_pend);
      end
    end
    en = 1'b1;
    step();
    n_cmp++;
    if (an !== 8'hDF || digit !== 3'd5 || pending !== 1'b1) begin
      n_bad++;
      $display("FAIL resume: an=%h digit=%0d pending=%b, required DF 5 1", an, digit, pending);
    end
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++;
    if (an !== 8'hFF || seg !== 8'hFF || digit !== 3'd0 || pending !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_reset: an=%h seg=%h digit=%0d pending=%b, required FF FF 0 0",
               an, seg, digit, pending);
    end
    for (int k = 0; k < 2 * FRAME; k++) begin
      step();
      n_cmp++;
      if (an !== e_an || seg !== e_seg || digit !== e_dig || pending !== e_pend ||
          seg[6:0] === hexlut[8]) begin
        n_bad++;
        $display("FAIL post_reset: an=%h seg=%h digit=%0d pending=%b, required an=%h seg=%h digit=%0d pending=%b",
                 an, seg, digit, pending, e_an, e_seg, e_dig, e_pend);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      rst   = ($urandom_range(0, 599) == 0);
      en    = ($urandom_range(0, 9) != 0);
      load  = ($urandom_range(0, 24) == 0);
      data  = ($urandom_range(0, 1) != 0) ? $urandom : ($urandom & 32'h0000_0FFF);
      point = 8'($urandom);
      blank = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      if ($urandom_range(0, 99) == 0) lz_en = ~lz_en;
      step();
      n_cmp++;
      if (an !== e_an || seg !== e_seg || digit !== e_dig || pending !== e_pend) begin
        n_bad++;
        $display("FAIL random: an=%h seg=%h digit=%0d pending=%b, required an=%h seg=%h digit=%0d pending=%b",
                 an, seg, digit, pending, e_an, e_seg, e_dig, e_pend);
      end
    end
    rst = 1'b0; load = 1'b0; en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_first_load();
    test_tear_free();
    test_boundary_load();
    test_leading_zero();
    test_masks();
    test_freeze_and_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
